// File: rtl/seg_display_pkg.sv
// Shared definitions for the multi-digit 7-segment display controller:
// active-low segment patterns, the BCD converter state type and a decoder.
package seg_display_pkg;

    // Segment patterns, bit order {dp,g,f,e,d,c,b,a}, active-low, dp off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } conv_state_t;

    // Non-decimal nibbles cannot come out of the converter; show them blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw active-low push-button -> 2-FF synchroniser -> debounce filter ->
// one-cycle pulse on each accepted press (stable 1->0). Releases are silent.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_meta;
    logic             sync_lvl;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button level into the clock domain (idle = released = 1).
    // NOTE: registers are written with <= so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_lvl  <= 1'b1;
        end else begin
            sync_meta <= btn_n;
            sync_lvl  <= sync_meta;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples; pulse on press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else if (sync_lvl != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_lvl;
                cnt    <= '0;
                press  <= ~sync_lvl;
            end else begin
                cnt    <= cnt + CNT_W'(1);
                press  <= 1'b0;
            end
        end else begin
            // Any return to the accepted level restarts the qualification window.
            cnt   <= '0;
            press <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Multi-digit 7-segment controller: debounced up/down buttons drive a decimal
// wrap-around counter, a sequential double-dabble converter feeds a display
// BCD register, and a prescaled scanner drives one digit at a time.
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int COUNT_W         = 14,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SCAN_DIV        = 50000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_countUp,
    input  logic                  i_countDown,
    input  logic                  i_blankLZ,
    output logic [NUM_DIGITS-1:0] o_digitSelect,
    output logic [7:0]            o_LED,
    output logic [COUNT_W-1:0]    o_count,
    output logic                  o_wrap
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int ITER_W = $clog2(COUNT_W + 1);
    localparam int PRE_W  = $clog2(SCAN_DIV + 1);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(10 ** NUM_DIGITS - 1);

    logic                  rst_meta;
    logic                  rst_n;
    logic                  up_pulse;
    logic                  down_pulse;
    logic                  count_change;

    conv_state_t           state;
    logic                  dirty;
    logic [COUNT_W-1:0]    shift_bin;
    logic [BCD_W-1:0]      bcd_work;
    logic [BCD_W-1:0]      bcd_adj;
    logic [ITER_W-1:0]     iter;
    logic [BCD_W-1:0]      bcd_disp;

    logic [PRE_W-1:0]      prescale;
    logic [IDX_W-1:0]      digit_idx;
    logic [IDX_W-1:0]      next_idx;
    logic                  scan_active;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic [7:0]            next_seg;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk   (i_clk),
        .rst_n (rst_n),
        .btn_n (i_countUp),
        .press (up_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk   (i_clk),
        .rst_n (rst_n),
        .btn_n (i_countDown),
        .press (down_pulse)
    );

    // Simultaneous presses cancel, so only an exclusive pulse moves the count.
    assign count_change = up_pulse ^ down_pulse;

    // Decimal up/down counter wrapping between 0 and MAX_COUNT.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_count <= '0;
            o_wrap  <= 1'b0;
        end else begin
            o_wrap <= 1'b0;
            if (up_pulse && !down_pulse) begin
                if (o_count == MAX_COUNT) begin
                    o_count <= '0;
                    o_wrap  <= 1'b1;
                end else begin
                    o_count <= o_count + COUNT_W'(1);
                end
            end else if (down_pulse && !up_pulse) begin
                if (o_count == '0) begin
                    o_count <= MAX_COUNT;
                    o_wrap  <= 1'b1;
                end else begin
                    o_count <= o_count - COUNT_W'(1);
                end
            end
        end
    end

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    // NOTE: combinational blocks assign every output a default first and use blocking '=' so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM: latch count, shift COUNT_W times, publish to the display register.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dirty     <= 1'b0;
            shift_bin <= '0;
            bcd_work  <= '0;
            iter      <= '0;
            bcd_disp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dirty) begin
                        shift_bin <= o_count;
                        bcd_work  <= '0;
                        iter      <= '0;
                        dirty     <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_work, shift_bin} <= {bcd_adj, shift_bin} << 1;
                    iter <= iter + ITER_W'(1);
                    if (iter == ITER_W'(COUNT_W - 1)) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bcd_disp <= bcd_work;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A change in any state (including mid-conversion) queues one more pass; this
            // write comes last so it wins over the IDLE clear in the same cycle.
            if (count_change) begin
                dirty <= 1'b1;
            end
        end
    end

    // Next digit to drive and its segment pattern, with leading-zero suppression.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run && (bcd_disp[4*i +: 4] == 4'd0);
            lead_zero[i] = run && (i != 0);
        end

        next_idx = '0;
        if (scan_active && (digit_idx != IDX_W'(NUM_DIGITS - 1))) begin
            next_idx = digit_idx + IDX_W'(1);
        end

        next_seg = seg_decode(bcd_disp[4*next_idx +: 4]);
        if (i_blankLZ && lead_zero[next_idx]) begin
            next_seg = SEG_BLANK;
        end
    end

    // Scan prescaler: select and segments change together on terminal count.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale      <= '0;
            digit_idx     <= '0;
            scan_active   <= 1'b0;
            o_digitSelect <= '1;
            o_LED         <= SEG_BLANK;
        end else if (prescale == PRE_W'(SCAN_DIV - 1)) begin
            prescale      <= '0;
            scan_active   <= 1'b1;
            digit_idx     <= next_idx;
            o_digitSelect <= ~(NUM_DIGITS'(1) << next_idx);
            o_LED         <= next_seg;
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: a decimal model of the counter
// queues expected count updates, a monitor pops them whenever the DUT count
// moves or o_wrap fires, and scan checks compare every digit's segments.
module tb_seg_display_ctrl;

    localparam int ND    = 4;
    localparam int CW    = 20;
    localparam int DB    = 3;
    localparam int SD    = 8;
    localparam int MAXV  = 9999;
    localparam int SETTLE = 2 * (CW + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          up_n;
    logic          dn_n;
    logic          blank_lz;
    logic [ND-1:0] sel;
    logic [7:0]    led;
    logic [CW-1:0] count;
    logic          wrap;

    typedef struct {
        int count;
        bit wrap;
    } exp_t;

    exp_t   exp_q[$];
    int     model_count = 0;
    int     vectors     = 0;
    int     miscompares = 0;
    int     prev_count  = 0;
    bit     watch_bcd   = 1'b0;
    bit     seen42      = 1'b0;

    seg_display_ctrl #(
        .NUM_DIGITS      (ND),
        .COUNT_W         (CW),
        .DEBOUNCE_CYCLES (DB),
        .SCAN_DIV        (SD)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_countUp     (up_n),
        .i_countDown   (dn_n),
        .i_blankLZ     (blank_lz),
        .o_digitSelect (sel),
        .o_LED         (led),
        .o_count       (count),
        .o_wrap        (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_seg(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every count movement or wrap pulse must match the next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            prev_count = 0;
        end else if (int'(count) != prev_count || wrap) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_update: count=%0d wrap=%0b, no update expected", count, wrap);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(count) != e.count || wrap !== e.wrap) begin
                    miscompares++;
                    $display("FAIL count_update: got count=%0d wrap=%0b, expected count=%0d wrap=%0b",
                             count, wrap, e.count, e.wrap);
                end
            end
            prev_count = int'(count);
        end
    end

    // Records whether the display register ever held a skipped intermediate value.
    always @(negedge clk) begin
        if (watch_bcd && dut.bcd_disp == 16'h0042) seen42 = 1'b1;
    end

    // Model the decimal counter, queue the expectation, then drive one clean press.
    task automatic press(input bit up, input bit dn, input int gap);
        if (up && !dn) begin
            if (model_count == MAXV) begin
                model_count = 0;
                exp_q.push_back('{0, 1'b1});
            end else begin
                model_count++;
                exp_q.push_back('{model_count, 1'b0});
            end
        end else if (dn && !up) begin
            if (model_count == 0) begin
                model_count = MAXV;
                exp_q.push_back('{MAXV, 1'b1});
            end else begin
                model_count--;
                exp_q.push_back('{model_count, 1'b0});
            end
        end
        up_n = !up;
        dn_n = !dn;
        tick(DB + 1);
        up_n = 1'b1;
        dn_n = 1'b1;
        tick(DB + 1 + gap);
    endtask

    task automatic goto_count(input int target);
        while (model_count != target) press(1'b1, 1'b0, $urandom_range(0, 3));
    endtask

    // After reset release, digit 0 must come up first, showing zero, after one scan period.
    task automatic first_enable_check();
        int n;
        bit ok;
        n = 0;
        while (sel == '1 && n < SD + 8) begin
            @(negedge clk);
            n++;
        end
        ok = (n >= SD) && (n <= SD + 3);
        check("first_enable_delay_ok", 32'(ok), 32'd1);
        check("first_enable_select", 32'(sel), 32'(4'b1110));
        check("first_enable_segments", 32'(led), 32'(8'hC0));
    endtask

    // Let the converter settle, then compare one full scan round against the model.
    task automatic check_display(input bit blank);
        logic [ND-1:0] last_sel;
        int seen;
        int n;
        blank_lz = blank;
        tick(SETTLE);
        check("count_value", 32'(count), 32'(model_count));
        last_sel = sel;
        seen = 0;
        n = 0;
        while (seen < ND && n < (ND + 1) * SD + 4) begin
            @(negedge clk);
            n++;
            if (sel != last_sel) begin
                int idx;
                int d;
                logic [7:0] e;
                last_sel = sel;
                idx = -1;
                for (int i = 0; i < ND; i++) begin
                    if (sel == ~(ND'(1) << i)) idx = i;
                end
                if (idx < 0) begin
                    check("digit_select_onehot", 32'(sel), 32'hFFFF_FFFF);
                end else begin
                    d = (model_count / (10 ** idx)) % 10;
                    e = (blank && idx != 0 && model_count < 10 ** idx) ? 8'hFF : exp_seg(d);
                    check($sformatf("digit%0d_segments_cnt%0d_blank%0b", idx, model_count, blank),
                          32'(led), 32'(e));
                end
                seen++;
            end
        end
        check("scan_round_complete", 32'(seen), 32'(ND));
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        up_n     = 1'b1;
        dn_n     = 1'b1;
        blank_lz = 1'b0;
        tick(3);
        check("reset_select", 32'(sel), 32'(4'hF));
        check("reset_segments", 32'(led), 32'(8'hFF));
        check("reset_count", 32'(count), 32'd0);
        check("reset_wrap", 32'(wrap), 32'd0);
        rst = 1'b1;
        first_enable_check();
        #1;

        // Reset in the middle of a scan slot while showing 37.
        goto_count(37);
        tick(SETTLE + $urandom_range(1, 20));
        check("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("midscan_reset_select", 32'(sel), 32'(4'hF));
        check("midscan_reset_segments", 32'(led), 32'(8'hFF));
        check("midscan_reset_count", 32'(count), 32'd0);
        model_count = 0;
        tick(3);
        rst = 1'b1;
        first_enable_check();
        #1;

        // Bouncy press held 3*DB: exactly one increment.
        model_count = 1;
        exp_q.push_back('{1, 1'b0});
        for (int i = 0; i < 5; i++) begin
            up_n = i[0];
            tick(1);
        end
        up_n = 1'b0;
        tick(3 * DB);
        for (int i = 0; i < 5; i++) begin
            up_n = ~i[0];
            tick(1);
        end
        up_n = 1'b1;
        tick(DB + 6);
        check("bounce_single_increment", 32'(count), 32'd1);

        // Glitch one cycle shorter than the debounce window: no change.
        up_n = 1'b0;
        tick(DB - 1);
        up_n = 1'b1;
        tick(DB + 6);
        check("short_glitch_ignored", 32'(count), 32'd1);
        check_display(1'b0);
        check_display(1'b1);

        // Wrap both directions at the boundaries.
        press(1'b0, 1'b1, 0);
        press(1'b0, 1'b1, 0);
        check_display(1'b1);
        press(1'b1, 1'b0, 0);
        press(1'b0, 1'b1, 0);
        press(1'b1, 1'b0, 0);
        check("after_wraps_count", 32'(count), 32'd0);

        // Count 7: leading zeros with and without blanking.
        goto_count(7);
        check_display(1'b1);
        check_display(1'b0);

        // Two further changes during one conversion: 42 is never displayed.
        goto_count(40);
        tick(SETTLE);
        seen42 = 1'b0;
        watch_bcd = 1'b1;
        press(1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 0);
        press(1'b1, 1'b0, 0);
        tick(SETTLE);
        watch_bcd = 1'b0;
        check("intermediate_42_skipped", 32'(seen42), 32'd0);
        check("bcd_register_43", 32'(dut.bcd_disp), 32'h0043);
        check_display(1'b0);

        // Simultaneous up and down at 500: no movement, no wrap.
        goto_count(500);
        press(1'b1, 1'b1, 4);
        check("both_pressed_hold", 32'(count), 32'd500);

        // Internal zero with blanking enabled.
        goto_count(1005);
        check_display(1'b1);
        check_display(1'b0);

        // Random mix of presses.
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 4; j++) begin
                int r;
                r = $urandom_range(0, 3);
                press(r != 1, r == 1 || r == 2, $urandom_range(0, 3));
            end
            check_display(1'($urandom_range(0, 1)));
        end

        tick(DB + 8);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Parametrised multi-digit 7-segment display controller; next generation of the single-button 4-digit counter display.
- Takes two raw push-buttons (up, down) and produces time-multiplexed segment/digit drives for NUM_DIGITS digits.
- Adds debounce, up/down counting with decimal wrap, a sequential double-dabble BCD converter and optional leading-zero blanking.
- Sits directly below the board top level.

Parameters:
- NUM_DIGITS, 4, number of displayed decimal digits (1..8).
- COUNT_W, 14, counter width; must satisfy 2^COUNT_W > 10^NUM_DIGITS-1.
- DEBOUNCE_CYCLES, 20000, clock cycles a synchronised button level must hold before it is accepted.
- SCAN_DIV, 50000, clock cycles each digit is driven before advancing.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-low reset
- i_countUp  input  1  raw up button, active-low (pressed = 0)
- i_countDown  input  1  raw down button, active-low (pressed = 0)
- i_blankLZ  input  1  1 = blank leading zeros
- o_digitSelect  output  NUM_DIGITS  one-hot digit enable, active-low
- o_LED  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
- o_count  output  COUNT_W  current binary count
- o_wrap  output  1  one-cycle pulse when the count wraps in either direction

Behaviour:
- Reset (i_rst=0, async assert, sync deassert internally): count=0, BCD register=0, converter IDLE, digit index=0, prescaler=0, o_digitSelect=all 1s, o_LED=8'hFF, o_wrap=0.
- Buttons:
  - Each button passes a 2-FF synchroniser into a debounce counter that resets on any level change.
  - The stable level updates after DEBOUNCE_CYCLES equal samples.
  - A press (stable 1->0) produces a one-cycle pulse. Releases produce nothing.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Counter (MAX = 10^NUM_DIGITS-1):
  - Up pulse: count+1; at MAX, wraps to 0 and pulses o_wrap.
  - Down pulse: count-1; at 0, wraps to MAX and pulses o_wrap.
  - Both pulses in the same cycle: no change, no o_wrap.
  - Count updates the cycle after the pulse.
- Converter FSM:
  - IDLE: if dirty, latch count into the shift register, clear dirty, go to SHIFT.
  - SHIFT: COUNT_W iterations of add-3-if-≥5 then shift left 1, one iteration per cycle; then go to LOAD.
  - LOAD: copy result into the display BCD register (all 4*NUM_DIGITS bits in one cycle), return to IDLE.
  - Dirty is set on every count change, including one made during SHIFT. That causes exactly one further conversion with the newest value, so intermediate values may be skipped.
  - Latency from count change to display register update: COUNT_W+2 cycles when IDLE.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. On terminal count the digit index advances 0→NUM_DIGITS-1→0.
  - The first enable after reset is digit 0, asserted at prescaler terminal count.
  - From then on, exactly one o_digitSelect bit is low.
  - o_LED is registered and changes in the same cycle as o_digitSelect, so no ghosting.
- Decode:
  - Digit values 0-9 use standard patterns; dp is always off (bit7=1).
  - BCD values 10-15 cannot occur; they decode to blank (8'hFF).
- Leading-zero blanking (i_blankLZ=1): a digit is blanked (o_LED=8'hFF, digit still selected) if it and every more significant digit are 0. Digit 0 is never blanked.

Decomposition:
- Package seg_display_pkg: segment encoding constants SEG_0..SEG_9, SEG_BLANK; converter state enum {IDLE,SHIFT,LOAD}.
- Sub-module button_debounce (synchroniser + debounce + press-edge pulse); instantiated twice.
- Counter, converter, scan and decode stay in the top body.

Test Plan:
- Reset mid-scan with count=37 → o_digitSelect=4'b1111, o_LED=8'hFF, o_count=0 immediately; after SCAN_DIV cycles digit0 shows SEG_0.
- Up press held 3*DEBOUNCE_CYCLES, with 5-cycle bounce at the edges → o_count 0→1 exactly once; a pulse of DEBOUNCE_CYCLES-1 gives no change.
- Count=9999, one up press → o_count=0, o_wrap high exactly 1 cycle; then a down press → o_count=9999, o_wrap pulses again.
- Up and down pulses forced in the same cycle at count=500 → o_count stays 500, no o_wrap.
- Count changes 41→42 mid-SHIFT, then 42→43 still mid-SHIFT → BCD register goes 41→43 (one extra conversion); a scoreboard across all digits matches decimal(o_count) within 2*(COUNT_W+2) cycles.
- Count=7, i_blankLZ=1 → digits 3..1 show 8'hFF, digit0 shows SEG_7. With i_blankLZ=0 → digits 3..1 show SEG_0. Count=1005 with blanking → digit2 (an internal zero) shows SEG_0.
